// File: rtl/idma_fifo_rr_sched_pkg.sv
// Shared types and defaults for the iDMA read-path round-robin FIFO scheduler.
// Pure declarations: no logic, no latency, no flow control.
package idma_fifo_rr_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_INIT  = 2'd2
  } state_e;

  localparam int unsigned IDMA_NUM_CH = 4;
  localparam int unsigned IDMA_DATA_W = 128;

  // Channel id width: ceil(log2(n)), never less than one bit.
  function automatic int unsigned ch_id_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/idma_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from last+1 with wrap.
// Zero latency; no flow control.
module idma_rr_pick
  import idma_fifo_rr_sched_pkg::*;
#(
  parameter int unsigned NUM_CH  = IDMA_NUM_CH,
  parameter int unsigned CH_ID_W = ch_id_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0]  req,
  input  logic [CH_ID_W-1:0] last,
  output logic [CH_ID_W-1:0] gnt_id,
  output logic               gnt_vld
);

  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_id  = '0;
    gnt_vld = 1'b0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      idx = (32'(last) + k) % NUM_CH;
      if (!gnt_vld && req[CH_ID_W'(idx)]) begin
        gnt_vld = 1'b1;
        gnt_id  = CH_ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/idma_fifo_rr_sched.sv
// Round-robin burst scheduler draining NUM_CH read FIFOs into one registered output slot.
// Pop-to-beat latency 1 cycle, one bubble per grant; pops only while the slot is free.
module idma_fifo_rr_sched
  import idma_fifo_rr_sched_pkg::*;
#(
  parameter int unsigned NUM_CH  = IDMA_NUM_CH,
  parameter int unsigned DATA_W  = IDMA_DATA_W,
  parameter int unsigned BL_W    = 6,
  parameter int unsigned CH_ID_W = ch_id_width(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BL_W-1:0]          cfg_burst_len,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH-1:0]        ch_empty,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_pop,
  input  logic [NUM_CH-1:0]        ch_init_req,
  output logic [NUM_CH-1:0]        ch_fifo_init,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_ID_W-1:0]       out_ch_id,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

  state_e              state_q;
  logic [CH_ID_W-1:0]  last_grant_q, grant_q;
  logic [BL_W-1:0]     blen_q, beat_cnt_q;
  logic [NUM_CH-1:0]   init_pend_q, init_pend_d;
  logic [NUM_CH-1:0]   ch_fifo_init_q;
  logic                out_valid_q, out_last_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [CH_ID_W-1:0]  out_ch_id_q;

  logic [NUM_CH-1:0]   pick_req;
  logic [CH_ID_W-1:0]  pick_id, init_sel;
  logic                pick_vld;
  logic [DATA_W-1:0]   g_data;
  logic                slot_free, pop_go, last_beat;

  assign pick_req  = ch_en & ~ch_empty;
  assign slot_free = !out_valid_q || out_ready;
  assign pop_go    = (state_q == ST_BURST) && ch_en[grant_q] && !ch_empty[grant_q] && slot_free;
  assign last_beat = (beat_cnt_q == BL_W'(blen_q - 1'b1));

  idma_rr_pick #(
    .NUM_CH  (NUM_CH),
    .CH_ID_W (CH_ID_W)
  ) u_pick (
    .req     (pick_req),
    .last    (last_grant_q),
    .gnt_id  (pick_id),
    .gnt_vld (pick_vld)
  );

  always_comb begin
    g_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_q == CH_ID_W'(i)) g_data = ch_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    init_sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (init_pend_q[i]) init_sel = CH_ID_W'(i);
    end
  end

  always_comb begin
    ch_pop          = '0;
    ch_pop[grant_q] = pop_go;
  end

  // The strobe register doubles as the clear mask; a new request still wins.
  assign init_pend_d = (init_pend_q & ~ch_fifo_init_q) | ch_init_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= CH_ID_W'(NUM_CH - 1);
      grant_q        <= '0;
      blen_q         <= BL_W'(1);
      beat_cnt_q     <= '0;
      init_pend_q    <= '0;
      ch_fifo_init_q <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_ch_id_q    <= '0;
      out_last_q     <= 1'b0;
    end else begin
      init_pend_q    <= init_pend_d;
      ch_fifo_init_q <= '0;

      if (pop_go) begin
        out_valid_q <= 1'b1;
        out_data_q  <= g_data;
        out_ch_id_q <= grant_q;
        out_last_q  <= last_beat;
        beat_cnt_q  <= beat_cnt_q + 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (|init_pend_q) begin
            ch_fifo_init_q <= ONE_HOT0 << init_sel;
            state_q        <= ST_INIT;
          end else if (pick_vld) begin
            grant_q      <= pick_id;
            last_grant_q <= pick_id;
            blen_q       <= (cfg_burst_len == '0) ? BL_W'(1) : cfg_burst_len;
            beat_cnt_q   <= '0;
            state_q      <= ST_BURST;
          end
        end
        ST_BURST: begin
          // Early end only once the slot could have taken a beat but the channel had none.
          if (pop_go ? last_beat : slot_free) state_q <= ST_IDLE;
        end
        ST_INIT: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ch_fifo_init = ch_fifo_init_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_ch_id    = out_ch_id_q;
  assign out_last     = out_last_q;
  assign busy         = (state_q != ST_IDLE) || out_valid_q;

endmodule

// File: tb/tb_idma_fifo_rr_sched.sv
// Scoreboard bench for idma_fifo_rr_sched with a behavioural FIFO model per channel.
module tb_idma_fifo_rr_sched;

  localparam int NUM_CH  = 4;
  localparam int DATA_W  = 128;
  localparam int BL_W    = 6;
  localparam int CH_ID_W = 2;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [BL_W-1:0]          cfg_burst_len;
  logic [NUM_CH-1:0]        ch_en, ch_empty, ch_pop, ch_init_req, ch_fifo_init;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic                     out_valid, out_last, out_ready, busy;
  logic [DATA_W-1:0]        out_data;
  logic [CH_ID_W-1:0]       out_ch_id;

  typedef struct packed {
    logic [CH_ID_W-1:0] ch;
    logic [DATA_W-1:0]  dat;
    logic               last;
  } beat_t;

  beat_t             exp_q[$];
  logic [DATA_W-1:0] mem [NUM_CH][64];
  logic [31:0]       wr [NUM_CH];
  logic [31:0]       rd [NUM_CH];
  logic [NUM_CH-1:0] pop_s;
  int                checks = 0;
  int                failures = 0;

  always #5 clk = ~clk;

  idma_fifo_rr_sched #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .BL_W(BL_W), .CH_ID_W(CH_ID_W)
  ) dut (
    .clk(clk), .rst(rst), .cfg_burst_len(cfg_burst_len), .ch_en(ch_en),
    .ch_empty(ch_empty), .ch_data(ch_data), .ch_pop(ch_pop),
    .ch_init_req(ch_init_req), .ch_fifo_init(ch_fifo_init),
    .out_valid(out_valid), .out_data(out_data), .out_ch_id(out_ch_id),
    .out_last(out_last), .out_ready(out_ready), .busy(busy)
  );

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_empty[i]                  = (rd[i] == wr[i]);
      ch_data[i*DATA_W +: DATA_W]  = mem[i][rd[i][5:0]];
    end
  end

  // FIFO read side: sample pops late in the cycle, advance just after the edge.
  initial begin
    for (int i = 0; i < NUM_CH; i++) rd[i] = 0;
    forever begin
      @(negedge clk); #2;
      pop_s = ch_pop;
      @(posedge clk); #1;
      for (int i = 0; i < NUM_CH; i++)
        if (pop_s[i] === 1'b1 && rd[i] != wr[i]) rd[i] = rd[i] + 1;
    end
  end

  function automatic logic [DATA_W-1:0] mk(input int c, input int n);
    mk = {32'hA5A5_0000 + 32'(c), 64'h0123_4567_89AB_CDEF, 32'(n)};
  endfunction

  task automatic load(input int c, input int n);
    for (int k = 0; k < n; k++) begin
      mem[c][wr[c][5:0]] = mk(c, int'(wr[c]));
      wr[c] = wr[c] + 1;
    end
  endtask

  task automatic expect_beat(input int c, input int n, input logic last);
    beat_t b;
    b.ch = CH_ID_W'(c); b.dat = mk(c, n); b.last = last;
    exp_q.push_back(b);
  endtask

  task automatic settle();
    ch_en = '0; ch_init_req = '0; out_ready = 1'b1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < NUM_CH; i++) wr[i] = rd[i];
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; ch_en = '0; ch_init_req = '0; out_ready = 1'b0; cfg_burst_len = 6'd4;
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || ch_pop !== '0 || ch_fifo_init !== '0 || busy !== 1'b0 ||
        out_last !== 1'b0 || out_data !== '0 || out_ch_id !== '0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b pop=%b init=%b busy=%b last=%b id=%0d, required all zero",
               out_valid, ch_pop, ch_fifo_init, busy, out_last, out_ch_id);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rr_order();
    int base [NUM_CH];
    int nb, prev;
    beat_t b;
    for (int c = 0; c < NUM_CH; c++) begin base[c] = int'(wr[c]); load(c, 8); end
    for (int k = 0; k < 17; k++)
      expect_beat((k / 4) % 4, base[(k / 4) % 4] + (k / 16) * 4 + k % 4, (k % 4) == 3);
    cfg_burst_len = 6'd4; out_ready = 1'b1; ch_en = 4'hF;
    nb = 0; prev = 0;
    for (int cyc = 0; cyc < 80 && nb < 17; cyc++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rr_extra_beat: got ch=%0d, required none", out_ch_id);
        end else begin
          b = exp_q.pop_front();
          if ({out_ch_id, out_data, out_last} !== {b.ch, b.dat, b.last}) begin
            failures++;
            $display("FAIL rr_beat%0d: got ch=%0d last=%b data=%h, required ch=%0d last=%b data=%h",
                     nb, out_ch_id, out_last, out_data, b.ch, b.last, b.dat);
          end
        end
        if (nb > 0) begin
          checks++;
          if (cyc - prev != ((nb % 4 == 0) ? 2 : 1)) begin
            failures++;
            $display("FAIL rr_gap%0d: got %0d cycles, required %0d", nb, cyc - prev, (nb % 4 == 0) ? 2 : 1);
          end
        end
        prev = cyc; nb++;
      end
    end
    ch_en = '0;
    checks++;
    if (nb != 17) begin failures++; $display("FAIL rr_count: got %0d beats, required 17", nb); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rr_after_disable: valid=%b, required 0", out_valid); end
  endtask

  task automatic test_early_end();
    int base, nb, npop;
    beat_t b;
    base = int'(wr[2]); load(2, 2);
    expect_beat(2, base, 1'b0); expect_beat(2, base + 1, 1'b0);
    cfg_burst_len = 6'd4; out_ready = 1'b1; ch_en = 4'b0100;
    nb = 0; npop = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (ch_pop != '0) npop++;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL early_extra_beat: got ch=%0d, required none", out_ch_id);
        end else begin
          b = exp_q.pop_front();
          if ({out_ch_id, out_data, out_last} !== {b.ch, b.dat, b.last}) begin
            failures++;
            $display("FAIL early_beat%0d: got ch=%0d last=%b data=%h, required ch=%0d last=%b data=%h",
                     nb, out_ch_id, out_last, out_data, b.ch, b.last, b.dat);
          end
        end
        nb++;
      end
    end
    checks++;
    if (nb != 2 || npop != 2 || busy !== 1'b0) begin
      failures++;
      $display("FAIL early_end: got beats=%0d pops=%0d busy=%b, required 2 2 0", nb, npop, busy);
    end
  endtask

  task automatic test_len_edges();
    int b0, b1, nb;
    beat_t b;
    b0 = int'(wr[0]); b1 = int'(wr[1]); load(0, 2); load(1, 2);
    expect_beat(0, b0, 1'b1); expect_beat(1, b1, 1'b1);
    expect_beat(0, b0 + 1, 1'b1); expect_beat(1, b1 + 1, 1'b1);
    b0 = int'(wr[3]); load(3, 63);
    for (int k = 0; k < 63; k++) expect_beat(3, b0 + k, k == 62);
    cfg_burst_len = 6'd0; out_ready = 1'b1; ch_en = 4'b0011;
    nb = 0;
    for (int cyc = 0; cyc < 160 && nb < 67; cyc++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL len_extra_beat: got ch=%0d, required none", out_ch_id);
        end else begin
          b = exp_q.pop_front();
          if ({out_ch_id, out_data, out_last} !== {b.ch, b.dat, b.last}) begin
            failures++;
            $display("FAIL len_beat%0d: got ch=%0d last=%b data=%h, required ch=%0d last=%b data=%h",
                     nb, out_ch_id, out_last, out_data, b.ch, b.last, b.dat);
          end
        end
        nb++;
        if (nb == 4) begin cfg_burst_len = 6'd63; ch_en = 4'b1000; end
      end
    end
    checks++;
    if (nb != 67) begin failures++; $display("FAIL len_count: got %0d beats, required 67", nb); end
  endtask

  task automatic test_stall();
    int base, nb;
    logic stalled, hl;
    logic [DATA_W-1:0] hd;
    logic [CH_ID_W-1:0] hc;
    beat_t b;
    base = int'(wr[1]); load(1, 4);
    for (int k = 0; k < 4; k++) expect_beat(1, base + k, k == 3);
    cfg_burst_len = 6'd4; ch_en = 4'b0010;
    nb = 0; stalled = 1'b0; hd = '0; hc = '0; hl = 1'b0;
    for (int cyc = 0; cyc < 60 && nb < 4; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== hd || out_ch_id !== hc || out_last !== hl) begin
          failures++;
          $display("FAIL stall_hold: got valid=%b ch=%0d data=%h, required 1 ch=%0d data=%h",
                   out_valid, out_ch_id, out_data, hc, hd);
        end
      end
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      #1;
      if (ch_pop != '0) begin
        checks++;
        if (ch_pop !== 4'b0010 || (out_valid && !out_ready)) begin
          failures++;
          $display("FAIL stall_pop: got pop=%b with valid=%b ready=%b, required pop=0010 only when slot free",
                   ch_pop, out_valid, out_ready);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL stall_extra_beat: got ch=%0d, required none", out_ch_id);
        end else begin
          b = exp_q.pop_front();
          if ({out_ch_id, out_data, out_last} !== {b.ch, b.dat, b.last}) begin
            failures++;
            $display("FAIL stall_beat%0d: got ch=%0d last=%b data=%h, required ch=%0d last=%b data=%h",
                     nb, out_ch_id, out_last, out_data, b.ch, b.last, b.dat);
          end
        end
        nb++;
      end
      stalled = out_valid && !out_ready; hd = out_data; hc = out_ch_id; hl = out_last;
    end
    checks++;
    if (nb != 4) begin failures++; $display("FAIL stall_count: got %0d beats, required 4", nb); end
  endtask

  task automatic test_init_mid_burst();
    int base, nb, ninit, init_cyc, last_pop;
    logic pulsed;
    beat_t b;
    base = int'(wr[1]); load(1, 4);
    for (int k = 0; k < 4; k++) expect_beat(1, base + k, k == 3);
    cfg_burst_len = 6'd4; out_ready = 1'b1; ch_en = 4'b0010;
    nb = 0; ninit = 0; init_cyc = -1; last_pop = 99; pulsed = 1'b0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      ch_init_req = '0;
      if (!pulsed && out_valid) begin ch_init_req = 4'b0010; pulsed = 1'b1; end
      if (ch_pop != '0) last_pop = cyc;
      if (ch_fifo_init != '0) begin
        ninit++; init_cyc = cyc;
        checks++;
        if (ch_fifo_init !== 4'b0010 || ch_pop !== '0) begin
          failures++;
          $display("FAIL init_strobe: got init=%b pop=%b, required 0010 0000", ch_fifo_init, ch_pop);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL init_extra_beat: got ch=%0d, required none", out_ch_id);
        end else begin
          b = exp_q.pop_front();
          if ({out_ch_id, out_data, out_last} !== {b.ch, b.dat, b.last}) begin
            failures++;
            $display("FAIL init_beat%0d: got ch=%0d last=%b data=%h, required ch=%0d last=%b data=%h",
                     nb, out_ch_id, out_last, out_data, b.ch, b.last, b.dat);
          end
        end
        nb++;
      end
    end
    checks++;
    if (nb != 4 || ninit != 1 || init_cyc <= last_pop) begin
      failures++;
      $display("FAIL init_after_burst: got beats=%0d inits=%0d init_cyc=%0d last_pop=%0d, required 4 1 init after pop",
               nb, ninit, init_cyc, last_pop);
    end
  endtask

  task automatic test_multi_init();
    logic [NUM_CH-1:0] seen[$];
    ch_en = '0;
    @(negedge clk);
    ch_init_req = 4'b1010;
    @(negedge clk);
    ch_init_req = '0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (ch_fifo_init != '0) seen.push_back(ch_fifo_init);
      @(negedge clk);
    end
    checks++;
    if (seen.size() != 2) begin
      failures++; $display("FAIL multi_init_count: got %0d strobes, required 2", seen.size());
    end else begin
      checks++;
      if (seen[0] !== 4'b0010 || seen[1] !== 4'b1000) begin
        failures++; $display("FAIL multi_init_order: got %b then %b, required 0010 then 1000", seen[0], seen[1]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    int b0, cyc;
    b0 = int'(wr[0]); load(0, 8); load(2, 8);
    cfg_burst_len = 6'd4; out_ready = 1'b0; ch_en = 4'b0101;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!out_valid && cyc < 10);
    checks++;
    if (out_valid !== 1'b1 || out_ch_id !== 2'd2) begin
      failures++; $display("FAIL rstmid_pre: got valid=%b ch=%0d, required 1 ch=2", out_valid, out_ch_id);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || ch_pop !== '0 || busy !== 1'b0 || ch_fifo_init !== '0) begin
      failures++;
      $display("FAIL rstmid_state: got valid=%b pop=%b busy=%b init=%b, required all zero",
               out_valid, ch_pop, busy, ch_fifo_init);
    end
    rst = 1'b0; out_ready = 1'b1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!out_valid && cyc < 10);
    checks++;
    if (out_valid !== 1'b1 || out_ch_id !== 2'd0 || out_data !== mk(0, b0) || out_last !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_first_grant: got valid=%b ch=%0d data=%h, required 1 ch=0 data=%h",
               out_valid, out_ch_id, out_data, mk(0, b0));
    end
    ch_en = '0;
  endtask

  initial begin
    rst = 1'b1; cfg_burst_len = 6'd4; ch_en = '0; ch_init_req = '0; out_ready = 1'b0;
    for (int i = 0; i < NUM_CH; i++) wr[i] = 0;
    test_reset();
    test_rr_order();        settle();
    test_early_end();       settle();
    test_len_edges();       settle();
    test_stall();           settle();
    test_init_mid_burst();  settle();
    test_multi_init();      settle();
    test_reset_mid_burst(); settle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
